uart_tx_engine: RTL and testbench

Transmit serializer for the UART. Pops bytes from the TX FIFO (FIFO_Contr plus register file) and shifts them out on the serial line as standard async frames: start bit, DBIT data bits LSB-first, optional parity, stop bit(s). Contains its own 16x oversampling tick divider so the datapath depends on no external baud logic.

---
 rtl/uart_tx_engine.sv | 96 +++++++++
 tb/tb_uart_tx_engine.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: UART frame serializer with 16x tick divider; ports clk, Reset, fifo_empty, fifo_rdata in; fifo_rd, tx, tx_busy, tx_done_tick out
module uart_tx_engine #(
  parameter int DBIT = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR = 326,
  parameter int PARITY_EN = 0,
  parameter int DVSR_W = 9
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_rdata,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);
  localparam int NW = $clog2(DBIT) + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [DVSR_W-1:0] c;
  logic [4:0] s, s_n;
  logic [NW-1:0] n, n_n;
  logic [DBIT-1:0] b, b_n;
  logic p, p_n, tx_n, tick, bit_end, stop_end;
  assign tick = c == DVSR_W'(DVSR - 1);
  assign bit_end = tick && s == 5'd15;
  assign stop_end = tick && s == 5'(SB_TICK - 1);
  assign tx_busy = state != IDLE;
  always_ff @(posedge clk or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      c <= '0;
      s <= '0;
      n <= '0;
      b <= '0;
      p <= 1'b0;
      tx <= 1'b1;
    end else begin
      state <= state_n;
      c <= (state == IDLE || tick) ? '0 : c + DVSR_W'(1);
      s <= s_n;
      n <= n_n;
      b <= b_n;
      p <= p_n;
      tx <= tx_n;
    end
  always_comb begin
    state_n = state;
    s_n = tick ? s + 5'd1 : s;
    n_n = n;
    b_n = b;
    p_n = p;
    fifo_rd = 1'b0;
    tx_done_tick = 1'b0;
    case (state)
      IDLE:
        if (!fifo_empty && !Reset) begin
          fifo_rd = 1'b1;
          b_n = fifo_rdata;
          p_n = 1'b0;
          s_n = '0;
          n_n = '0;
          state_n = START;
        end
      START:
        if (bit_end) begin
          s_n = '0;
          n_n = '0;
          state_n = DATA;
        end
      DATA:
        if (bit_end) begin
          s_n = '0;
          b_n = b >> 1;
          p_n = p ^ b[0];
          n_n = n + NW'(1);
          if (n == NW'(DBIT - 1)) state_n = (PARITY_EN != 0) ? PARITY : STOP;
        end
      PARITY:
        if (bit_end) begin
          s_n = '0;
          state_n = STOP;
        end
      STOP:
        if (stop_end) begin
          s_n = '0;
          tx_done_tick = 1'b1;
          state_n = IDLE;
        end
      default: state_n = IDLE;
    endcase
    // line level follows the state being entered so tx changes with the state register
    tx_n = (state_n == START) ? 1'b0 : (state_n == DATA) ? b_n[0] : (state_n == PARITY) ? p_n : 1'b1;
  end
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: directed scoreboard bench for three uart_tx_engine configurations
module tb_uart_tx_engine;
  logic clk, Reset, hold, qe, pp;
  logic [1:0] sel;
  logic [7:0] rdata_r;
  logic [2:0] fe, rd_v, tx_v, busy_v, done_v;
  logic [7:0] fq[$], exp_q[$];
  int tests, fails;
  assign fe = ~(3'b001 << sel) | {3{hold | qe}};
  uart_tx_engine #(.DBIT(8), .SB_TICK(16), .DVSR(4), .PARITY_EN(0), .DVSR_W(3)) u0 (
    .clk(clk), .Reset(Reset), .fifo_empty(fe[0]), .fifo_rdata(rdata_r),
    .fifo_rd(rd_v[0]), .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done_tick(done_v[0]));
  uart_tx_engine #(.DBIT(8), .SB_TICK(16), .DVSR(4), .PARITY_EN(1), .DVSR_W(3)) u1 (
    .clk(clk), .Reset(Reset), .fifo_empty(fe[1]), .fifo_rdata(rdata_r),
    .fifo_rd(rd_v[1]), .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done_tick(done_v[1]));
  uart_tx_engine #(.DBIT(7), .SB_TICK(32), .DVSR(2), .PARITY_EN(0), .DVSR_W(2)) u2 (
    .clk(clk), .Reset(Reset), .fifo_empty(fe[2]), .fifo_rdata(rdata_r[6:0]),
    .fifo_rd(rd_v[2]), .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done_tick(done_v[2]));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // FIFO model: flags refreshed at negedge, pop applied just after the edge that consumed the data
  always begin
    @(negedge clk);
    pp = rd_v[sel];
    qe = fq.size() == 0;
    rdata_r = qe ? 8'h00 : fq[0];
    @(posedge clk);
    #1;
    if (pp && fq.size() > 0) void'(fq.pop_front());
    qe = fq.size() == 0;
    rdata_r = qe ? 8'h00 : fq[0];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [7:0] d);
    fq.push_back(d);
    exp_q.push_back(d);
  endtask
  task automatic frame(input int dbit, input int par, input int dvsr, input int sb, input int span);
    int flen, bp, n, slot, bad, nd, done_at, extra, bbad;
    logic e_tx, pdec;
    logic [7:0] e, dec;
    flen = 1 + (1 + dbit + par) * 16 * dvsr + sb * dvsr;
    bp = 16 * dvsr;
    e = 8'hxx;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    dec = 8'h00;
    pdec = 1'b0;
    bad = 0;
    nd = 0;
    done_at = -1;
    extra = 0;
    bbad = 0;
    n = 0;
    @(negedge clk);
    while (!rd_v[sel] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("pop_seen", 32'(rd_v[sel]), 1);
    if (span > 0) chk("pop_span", flen + n + 1, span);
    for (int k = 0; k < flen; k++) begin
      if (k > 0) @(negedge clk);
      slot = k == 0 ? 0 : (k - 1) / bp;
      e_tx = (k == 0 || slot > dbit + par) ? 1'b1 : slot == 0 ? 1'b0 : slot <= dbit ? e[slot-1] : ^e;
      if (tx_v[sel] !== e_tx) bad++;
      if (k > 0 && (k - 1) % bp == bp / 2 && slot >= 1 && slot <= dbit) dec[slot-1] = tx_v[sel];
      if (k > 0 && (k - 1) % bp == bp / 2 && slot == dbit + 1 && par != 0) pdec = tx_v[sel];
      if (done_v[sel]) begin
        nd++;
        done_at = k;
      end
      if (k > 0 && rd_v[sel]) extra++;
      if (busy_v[sel] !== (k > 0)) bbad++;
    end
    chk("wave_bad_cycles", bad, 0);
    chk("data_byte", dec, e);
    if (par != 0) chk("parity_bit", 32'(pdec), 32'(^e));
    chk("done_at", done_at, flen - 1);
    chk("done_count", nd, 1);
    chk("extra_pops", extra, 0);
    chk("busy_bad_cycles", bbad, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    int n, cnt;
    tests = 0;
    fails = 0;
    Reset = 1'b1;
    hold = 1'b0;
    sel = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx_v), 32'h7);
    chk("rst_busy", 32'(busy_v), 0);
    chk("rst_rd", 32'(rd_v), 0);
    chk("rst_done", 32'(done_v), 0);
    Reset = 1'b0;
    push(8'hA5);
    frame(8, 0, 4, 16, -1);
    push(8'h00);
    push(8'hFF);
    push(8'h55);
    frame(8, 0, 4, 16, -1);
    frame(8, 0, 4, 16, 642);
    frame(8, 0, 4, 16, 642);
    repeat (4) @(negedge clk);
    sel = 2'd1;
    push(8'h07);
    frame(8, 1, 4, 16, -1);
    push(8'h03);
    frame(8, 1, 4, 16, -1);
    repeat (4) @(negedge clk);
    sel = 2'd0;
    push(8'h3C);
    push(8'hC3);
    fork
      frame(8, 0, 4, 16, -1);
      begin
        repeat (200) @(negedge clk);
        hold = 1'b1;
        repeat (400) @(negedge clk);
        hold = 1'b0;
      end
    join
    frame(8, 0, 4, 16, 642);
    repeat (4) @(negedge clk);
    push(8'h94);
    n = 0;
    @(negedge clk);
    while (!rd_v[0] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("rst_test_pop", 32'(rd_v[0]), 1);
    repeat (150) @(negedge clk);
    chk("pre_reset_busy", 32'(busy_v[0]), 1);
    chk("pre_reset_tx", 32'(tx_v[0]), 0);
    #2 Reset = 1'b1;
    #1;
    chk("async_rst_tx", 32'(tx_v[0]), 1);
    chk("async_rst_busy", 32'(busy_v[0]), 0);
    chk("async_rst_rd", 32'(rd_v[0]), 0);
    exp_q.delete();
    fq.push_back(8'h11);
    repeat (3) @(negedge clk);
    chk("rd_held_in_reset", 32'(rd_v[0]), 0);
    hold = 1'b1;
    Reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_v[0] !== 1'b1 || rd_v[0] !== 1'b0) cnt++;
    end
    chk("idle_after_reset", cnt, 0);
    fq.delete();
    repeat (2) @(negedge clk);
    hold = 1'b0;
    sel = 2'd2;
    push(8'h35);
    frame(7, 0, 2, 32, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
